// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit -- register-file write-back buffer
//
// Collects results from two producers (ALU and load unit) into a 4-entry
// FIFO and drains them one per cycle into the register-file write port.
// Loads are size/sign extended before they are stored. Only one offer is
// taken per edge, and a pending load always wins over the ALU.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   alu_valid/dest/data         ALU result offer
//   alu_ready                   ALU offer accepted this edge
//   ld_valid/dest/data          raw load word (data in the low bits)
//   ld_Eh, ld_Eb, ld_sext       load size (byte/half/word) and sign control
//   ld_ready                    load offer accepted this edge
//   wb_hold                     freezes register-file writes
//   addr3, data_in, write_d     register-file write port (FIFO head)
//   q_addr, q_hit               pending-write query
//   count                       FIFO occupancy, 0..4
//
// Configuration macro
//   WB_HAZARD_EN  when defined, q_hit reports whether any buffered entry
//                 targets q_addr; when undefined q_hit is tied to 0.
// ---------------------------------------------------------------------------
module wb_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_dest,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_dest,
   input  logic [31:0] ld_data,
   input  logic        ld_Eh,
   input  logic        ld_Eb,
   input  logic        ld_sext,
   output logic        ld_ready,
   input  logic        wb_hold,
   output logic [4:0]  addr3,
   output logic [31:0] data_in,
   output logic        write_d,
   input  logic [4:0]  q_addr,
   output logic        q_hit,
   output logic [2:0]  count
);

   logic [4:0]  dest_mem [4];
   logic [31:0] data_mem [4];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;

   logic        not_full;
   logic        not_empty;
   logic        ld_accept;
   logic        alu_accept;
   logic [31:0] ld_ext;
   logic [4:0]  push_dest;
   logic [31:0] push_data;
   logic        push;
   logic        pop;

   // Handshake: the load port only needs space; the ALU additionally
   // yields to a load offered in the same cycle. When full there is no
   // pass-through, even though the head may be popped this very edge.
   assign not_full   = (count < 3'd4);
   assign not_empty  = (count != 3'd0);
   assign ld_ready   = not_full;
   assign alu_ready  = not_full & ~ld_valid;
   assign ld_accept  = ld_valid & ld_ready;
   assign alu_accept = alu_valid & alu_ready;

   // Load extension: Eh=0 is a full word (sign control ignored),
   // Eh=1/Eb=1 a byte and Eh=1/Eb=0 a halfword.
   always_comb begin
      ld_ext = ld_data;
      if (ld_Eh) begin
         if (ld_Eb) begin
            ld_ext = {{24{ld_sext & ld_data[7]}}, ld_data[7:0]};
         end else begin
            ld_ext = {{16{ld_sext & ld_data[15]}}, ld_data[15:0]};
         end
      end
   end

   // Writes to r0 are accepted (handshake completes) but never buffered.
   assign push_dest = ld_accept ? ld_dest : alu_dest;
   assign push_data = ld_accept ? ld_ext : alu_data;
   assign push      = (ld_accept | alu_accept) & (push_dest != 5'd0);

   // Head of the FIFO drives the write port; outputs read as zero when
   // nothing is buffered so stale storage never leaks out.
   assign write_d = not_empty & ~wb_hold;
   assign pop     = write_d;
   assign addr3   = not_empty ? dest_mem[rd_ptr] : 5'd0;
   assign data_in = not_empty ? data_mem[rd_ptr] : 32'd0;

   // Pointers wrap naturally at 2 bits. count can never over/underflow
   // because push requires space and pop requires an entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         count <= count + {2'b00, push} - {2'b00, pop};
      end
   end

   // Storage needs no reset: validity is tracked purely by count/rd_ptr.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[wr_ptr] <= push_dest;
         data_mem[wr_ptr] <= push_data;
      end
   end

`ifdef WB_HAZARD_EN
   logic [1:0] slot;
   logic [1:0] slot_off;

   // A slot is live when its distance from the read pointer is below
   // count; this makes q_hit drop to 0 the moment reset clears count.
   always_comb begin
      q_hit    = 1'b0;
      slot     = 2'd0;
      slot_off = 2'd0;
      for (int i = 0; i < 4; i++) begin
         slot     = 2'(i);
         slot_off = slot - rd_ptr;
         if (({1'b0, slot_off} < count) && (dest_mem[slot] == q_addr) &&
             (q_addr != 5'd0)) begin
            q_hit = 1'b1;
         end
      end
   end
`else
   logic unused_q_addr;

   assign unused_q_addr = ^q_addr;
   assign q_hit         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_unit -- self-checking bench for wb_unit
//
// Directed stimulus pushes the expected register-file writes into a
// scoreboard queue; an independent monitor pops and compares every time
// the DUT presents write_d on the write port. Inputs change 1 time unit
// after the rising edge, and all sampling happens on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_unit;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_dest;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_dest;
   logic [31:0] ld_data;
   logic        ld_Eh;
   logic        ld_Eb;
   logic        ld_sext;
   logic        ld_ready;
   logic        wb_hold;
   logic [4:0]  addr3;
   logic [31:0] data_in;
   logic        write_d;
   logic [4:0]  q_addr;
   logic        q_hit;
   logic [2:0]  count;

   int          check_count = 0;
   int          error_count = 0;
   logic [36:0] exp_q[$];
   logic [36:0] mon_exp;

   wb_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_dest  (alu_dest),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .ld_valid  (ld_valid),
      .ld_dest   (ld_dest),
      .ld_data   (ld_data),
      .ld_Eh     (ld_Eh),
      .ld_Eb     (ld_Eb),
      .ld_sext   (ld_sext),
      .ld_ready  (ld_ready),
      .wb_hold   (wb_hold),
      .addr3     (addr3),
      .data_in   (data_in),
      .write_d   (write_d),
      .q_addr    (q_addr),
      .q_hit     (q_hit),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared by the stimulus and monitor processes, hence automatic.
   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, required %0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a load for one cycle; called 1 unit after a rising edge.
   task automatic send_ld(input logic [4:0] d, input logic [31:0] raw,
                          input logic eh, input logic eb, input logic sx,
                          input logic [31:0] expv);
      ld_valid = 1'b1;
      ld_dest  = d;
      ld_data  = raw;
      ld_Eh    = eh;
      ld_Eb    = eb;
      ld_sext  = sx;
      if (d != 5'd0) exp_q.push_back({d, expv});
      @(negedge clk);
      check_output("ld_ready", 64'(ld_ready), 64'(1));
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
   endtask

   // Offer an ALU result for one cycle and check the expected readiness.
   task automatic send_alu(input logic [4:0] d, input logic [31:0] v,
                           input logic exp_ready);
      alu_valid = 1'b1;
      alu_dest  = d;
      alu_data  = v;
      if (exp_ready && d != 5'd0) exp_q.push_back({d, v});
      @(negedge clk);
      check_output("alu_ready", 64'(alu_ready), 64'(exp_ready));
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
   endtask

   // Scoreboard monitor: every presented write must match the oldest
   // outstanding expectation, and no write may appear unannounced.
   always @(negedge clk) begin
      if (rst_n && write_d) begin
         if (exp_q.size() == 0) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL sb_unexpected_write: got addr3=%0d data_in=%h, required no write at %0t",
                     addr3, data_in, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check_output("sb_write", 64'({addr3, data_in}), 64'(mon_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      alu_valid = 1'b0;
      alu_dest  = 5'd0;
      alu_data  = 32'd0;
      ld_valid  = 1'b0;
      ld_dest   = 5'd0;
      ld_data   = 32'd0;
      ld_Eh     = 1'b0;
      ld_Eb     = 1'b0;
      ld_sext   = 1'b0;
      wb_hold   = 1'b0;
      q_addr    = 5'd0;

      #1;
      check_output("rst_count",   64'(count),   64'(0));
      check_output("rst_write_d", 64'(write_d), 64'(0));
      check_output("rst_q_hit",   64'(q_hit),   64'(0));
      check_output("rst_addr3",   64'(addr3),   64'(0));
      check_output("rst_data_in", 64'(data_in), 64'(0));
      #21 rst_n = 1'b1;
      idle(1);

      $display("[TB] signed byte load");
      send_ld(5'd5, 32'h0000_00AE, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFAE);
      @(negedge clk);
      check_output("byte_count",   64'(count),   64'(1));
      check_output("byte_write_d", 64'(write_d), 64'(1));
      @(posedge clk);
      #1;

      $display("[TB] load size and sign variants");
      send_ld(5'd6,  32'h00FF_FFAE, 1'b1, 1'b0, 1'b0, 32'h0000_FFAE);
      send_ld(5'd7,  32'h00FF_FFAE, 1'b0, 1'b0, 1'b0, 32'h00FF_FFAE);
      send_ld(5'd8,  32'h0000_8001, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001);
      send_ld(5'd9,  32'hFFFF_FF80, 1'b1, 1'b1, 1'b0, 32'h0000_0080);
      send_ld(5'd10, 32'h1234_80F0, 1'b0, 1'b1, 1'b1, 32'h1234_80F0);
      idle(3);

      $display("[TB] load beats ALU in the same cycle");
      alu_valid = 1'b1;
      alu_dest  = 5'd11;
      alu_data  = 32'h0000_00A1;
      ld_valid  = 1'b1;
      ld_dest   = 5'd12;
      ld_data   = 32'h0000_0055;
      ld_Eh     = 1'b0;
      ld_Eb     = 1'b0;
      ld_sext   = 1'b0;
      exp_q.push_back({5'd12, 32'h0000_0055});
      @(negedge clk);
      check_output("prio_ld_ready",  64'(ld_ready),  64'(1));
      check_output("prio_alu_ready", 64'(alu_ready), 64'(0));
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      exp_q.push_back({5'd11, 32'h0000_00A1});
      @(negedge clk);
      check_output("prio_alu_retry", 64'(alu_ready), 64'(1));
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
      idle(3);

      $display("[TB] write to r0 is dropped");
      send_alu(5'd0, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      check_output("r0_count",   64'(count),   64'(0));
      check_output("r0_write_d", 64'(write_d), 64'(0));
      @(posedge clk);
      #1;

      $display("[TB] fill under hold, then drain");
      wb_hold = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         send_alu(5'(k), 32'h1000_0000 + 32'(k), 1'b1);
      end
      alu_valid = 1'b1;
      alu_dest  = 5'd5;
      alu_data  = 32'h1000_0005;
      @(negedge clk);
      check_output("full_count",     64'(count),     64'(4));
      check_output("full_alu_ready", 64'(alu_ready), 64'(0));
      check_output("full_ld_ready",  64'(ld_ready),  64'(0));
      check_output("hold_write_d",   64'(write_d),   64'(0));
      @(posedge clk);
      #1;
      wb_hold = 1'b0;
      @(negedge clk);
      check_output("full_no_passthru", 64'(alu_ready), 64'(0));
      @(posedge clk);
      #1;
      exp_q.push_back({5'd5, 32'h1000_0005});
      @(negedge clk);
      check_output("drain_alu_ready", 64'(alu_ready), 64'(1));
      check_output("drain_count",     64'(count),     64'(3));
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
      @(negedge clk);
      check_output("push_pop_count", 64'(count), 64'(3));
      @(posedge clk);
      #1;
      idle(5);
      check_output("drained_count", 64'(count), 64'(0));

      $display("[TB] reset discards pending entries");
      wb_hold = 1'b1;
      send_alu(5'd20, 32'h0000_0020, 1'b1);
      send_alu(5'd21, 32'h0000_0021, 1'b1);
      send_alu(5'd22, 32'h0000_0022, 1'b1);
      // These three are never expected to be written; drop them again.
      repeat (3) void'(exp_q.pop_back());
      q_addr = 5'd21;
      @(negedge clk);
      check_output("pend_count", 64'(count), 64'(3));
`ifdef WB_HAZARD_EN
      check_output("hazard_hit", 64'(q_hit), 64'(1));
      q_addr = 5'd23;
      #1;
      check_output("hazard_miss", 64'(q_hit), 64'(0));
      q_addr = 5'd21;
`else
      check_output("hazard_off", 64'(q_hit), 64'(0));
`endif
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst_count",   64'(count),   64'(0));
      check_output("midrst_write_d", 64'(write_d), 64'(0));
      check_output("midrst_q_hit",   64'(q_hit),   64'(0));
      check_output("midrst_addr3",   64'(addr3),   64'(0));
      @(negedge clk);
      #2;
      rst_n   = 1'b1;
      wb_hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_output("postrst_count",   64'(count),   64'(0));
         check_output("postrst_write_d", 64'(write_d), 64'(0));
      end

      check_output("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge active.
REQ-002 SHALL have ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: alu_valid  in  1 / alu_dest  in  5 / alu_data  in  32  ALU result offer.
REQ-004 SHALL have ports: alu_ready  out  1  ALU offer accepted this edge.
REQ-005 SHALL have ports: ld_valid  in  1 / ld_dest  in  5 / ld_data  in  32  raw load word, data in low bits.
REQ-006 SHALL have ports: ld_Eh  in  1 / ld_Eb  in  1 / ld_sext  in  1  load size and sign control (Eh=1,Eb=1 byte; Eh=1,Eb=0 half; Eh=0 word).
REQ-007 SHALL have ports: ld_ready  out  1  load offer accepted this edge.
REQ-008 SHALL have ports: wb_hold  in  1  freezes register-file writes.
REQ-009 SHALL have ports: addr3  out  5 / data_in  out  32 / write_d  out  1  register-file write port.
REQ-010 SHALL have ports: q_addr  in  5 / q_hit  out  1  pending-write query.
REQ-011 SHALL have ports: count  out  3  FIFO occupancy, 0..4.

Function
REQ-012 SHALL hold a 4-entry FIFO of {dest[4:0], data[31:0]}, with a 2-bit read pointer, a 2-bit write pointer and a 3-bit count.
REQ-013 SHALL accept an offer on a rising edge when its valid and ready are both 1.
REQ-014 SHALL accept at most one offer per edge; ld has priority, so alu_ready = (count<4) & !ld_valid and ld_ready = (count<4).
REQ-015 SHALL accept but not enqueue an offer with dest == 0, and count SHALL be unchanged by it.
REQ-016 SHALL extend load data before enqueue: byte = ld_data[7:0], half = ld_data[15:0], word = ld_data as-is.
REQ-017 SHALL sign-extend byte and half loads when ld_sext=1 and zero-extend them otherwise; ld_sext SHALL be ignored for word loads.
REQ-018 SHALL drive addr3 and data_in combinationally from the FIFO head and set write_d = (count != 0) & !wb_hold.
REQ-019 SHALL pop the head on every edge where write_d = 1.
REQ-020 SHALL give a latency of one edge: an entry accepted at edge k is presented with write_d = 1 in cycle k+1 and written at edge k+1 if wb_hold = 0.
REQ-021 SHALL allow a push and a pop on the same edge, with count unchanged.
REQ-022 SHALL deassert both readys when full (count = 4), with no pass-through when full.
REQ-023 SHALL wrap both pointers modulo 4.
REQ-024 SHALL preserve FIFO order when one destination is written twice, so the later value lands last.
REQ-025 SHALL never let count exceed 4 or underflow below 0.

Reset
REQ-026 SHALL, while rst_n = 0, immediately force count = 0, both pointers = 0, write_d = 0 and q_hit = 0.
REQ-027 SHALL discard all pending entries on a reset during operation, and SHALL not write them.
REQ-028 SHALL drive addr3 and data_in to 0 while the FIFO is empty.

Configuration
REQ-029 SHALL, with macro WB_HAZARD_EN defined, drive q_hit = 1 combinationally when q_addr != 0 and any valid FIFO entry has dest == q_addr.
REQ-030 SHALL, with WB_HAZARD_EN undefined, keep the q_hit and q_addr ports, tie q_hit to 0 and ignore q_addr.

Verification
REQ-031 SHALL cover: ld_valid=1, dest=5, data=32'h0000_00AE, Eh=1, Eb=1, sext=1 -> next cycle write_d=1, addr3=5, data_in=32'hFFFF_FFAE.
REQ-032 SHALL cover: ld with Eh=1, Eb=0, sext=0, data=32'h00FF_FFAE -> data_in=32'h0000_FFAE; the same load with Eh=0 -> 32'h00FF_FFAE.
REQ-033 SHALL cover: alu_valid and ld_valid both 1 in one cycle -> load enqueued, alu_ready=0, ALU offer enqueued next edge, write order load then ALU.
REQ-034 SHALL cover: wb_hold=1 with 5 ALU offers to dests 1..5 -> count=4, alu_ready=0 on the 5th; release wb_hold -> writes to 1,2,3,4,5 on consecutive edges.
REQ-035 SHALL cover: ALU offer with dest=0 -> alu_ready=1, count stays 0, write_d stays 0.
REQ-036 SHALL cover: with WB_HAZARD_EN, 3 entries pending, rst_n pulsed low mid-cycle -> count=0, write_d=0 and q_hit=0 immediately, with no later writes.
